// File: rtl/packet_generator.sv
// packet_generator: transmit side of the 16-bit packet protocol.
// Emits bursts of framed packets {header, payload, sequence} and can corrupt
// the second packet of a burst (header or sequence) for checker testing.
module packet_generator #(
    parameter int BUS_SIZE     = 16,
    parameter int WORD_SIZE    = 4,
    parameter int PAYLOAD_SIZE = BUS_SIZE - 2*WORD_SIZE
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [WORD_SIZE-1:0]    pkt_count,
    input  logic [1:0]              err_mode,
    input  logic [PAYLOAD_SIZE-1:0] payload,
    output logic [BUS_SIZE-1:0]     data_bus,
    output logic                    busy,
    output logic                    done,
    output logic [WORD_SIZE-1:0]    seq
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_HDR  = 2'b01;
    localparam logic [1:0] ERR_SEQ  = 2'b10;

    localparam logic [WORD_SIZE-1:0] HDR_OK  = {WORD_SIZE{1'b1}};
    localparam logic [WORD_SIZE-1:0] HDR_BAD = {{(WORD_SIZE-1){1'b1}}, 1'b0};
    // pkt_count of 0 requests a full 2^WORD_SIZE packet burst
    localparam logic [WORD_SIZE:0]   FULL_CNT = {1'b1, {WORD_SIZE{1'b0}}};
    localparam logic [WORD_SIZE:0]   ONE_CNT  = {{WORD_SIZE{1'b0}}, 1'b1};

    logic [1:0]              state_q, state_d;
    logic [WORD_SIZE:0]      rem_q, rem_d;
    logic [WORD_SIZE:0]      idx_q, idx_d;
    logic [WORD_SIZE-1:0]    cnt_q, cnt_d;
    logic [1:0]              err_q, err_d;
    logic [BUS_SIZE-1:0]     data_q, data_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [WORD_SIZE-1:0]    seq_q, seq_d;
    logic [WORD_SIZE-1:0]    hdr;
    logic [WORD_SIZE-1:0]    pkt_seq;

    // Next-state and next-output computation for the IDLE/SEND/DONE sequencer
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        data_d  = '0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        seq_d   = '0;
        hdr     = HDR_OK;
        pkt_seq = cnt_q;
        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    state_d = ST_SEND;
                    rem_d   = (pkt_count == '0) ? FULL_CNT : {1'b0, pkt_count};
                    idx_d   = '0;
                    cnt_d   = '0;
                    // mode 11 is reserved and behaves as no error
                    err_d   = (err_mode == 2'b11) ? ERR_NONE : err_mode;
                    busy_d  = 1'b1;
                end
            end
            ST_SEND: begin
                // only the second packet of a burst is ever corrupted
                if (idx_q == ONE_CNT && err_q == ERR_HDR) begin
                    hdr = HDR_BAD;
                end
                if (idx_q == ONE_CNT && err_q == ERR_SEQ) begin
                    pkt_seq = cnt_q + 1'b1;
                end
                data_d = {hdr, payload, pkt_seq};
                seq_d  = pkt_seq;
                // later packets continue from whatever sequence was just sent
                cnt_d  = pkt_seq + 1'b1;
                idx_d  = idx_q + 1'b1;
                rem_d  = rem_q - 1'b1;
                busy_d = 1'b1;
                if (rem_q == ONE_CNT) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset clears everything asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            err_q   <= ERR_NONE;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            seq_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            seq_q   <= seq_d;
        end
    end

    assign data_bus = data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign seq      = seq_q;

endmodule

// File: tb/tb_packet_generator.sv
// Directed testbench for packet_generator.
module tb_packet_generator;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  pkt_count;
    logic [1:0]  err_mode;
    logic [7:0]  payload;
    logic [15:0] data_bus;
    logic        busy;
    logic        done;
    logic [3:0]  seq;

    int checks = 0;
    int errors = 0;

    packet_generator #(.BUS_SIZE(16), .WORD_SIZE(4)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .pkt_count(pkt_count),
        .err_mode(err_mode),
        .payload(payload),
        .data_bus(data_bus),
        .busy(busy),
        .done(done),
        .seq(seq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Request a burst; after the accepting edge busy is high and the bus still idle
    task automatic launch(input logic [3:0] c, input logic [1:0] m, input logic [7:0] pl);
        pkt_count = c;
        err_mode  = m;
        payload   = pl;
        start     = 1'b1;
        tick();
        start = 1'b0;
        chk("launch_busy", 16'(busy), 16'd1);
        chk("launch_bus", data_bus, 16'h0000);
    endtask

    task automatic pkt(input string tag, input logic [15:0] exp_bus, input logic [3:0] exp_seq);
        tick();
        chk(tag, data_bus, exp_bus);
        chk({tag, "_seq"}, 16'(seq), 16'(exp_seq));
        chk({tag, "_busy"}, 16'(busy), 16'd1);
        chk({tag, "_done"}, 16'(done), 16'd0);
    endtask

    task automatic finish_burst(input string tag);
        tick();
        chk({tag, "_done"}, 16'(done), 16'd1);
        chk({tag, "_busy"}, 16'(busy), 16'd0);
        chk({tag, "_bus"}, data_bus, 16'h0000);
        chk({tag, "_seq"}, 16'(seq), 16'd0);
        tick();
        chk({tag, "_done_low"}, 16'(done), 16'd0);
        chk({tag, "_idle_bus"}, data_bus, 16'h0000);
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        pkt_count = 4'd0;
        err_mode  = 2'b00;
        payload   = 8'h00;

        // reset asserted mid-cycle clears outputs before any clock edge
        #2 reset = 1'b1;
        #1;
        chk("rst_bus", data_bus, 16'h0000);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_done", 16'(done), 16'd0);
        chk("rst_seq", 16'(seq), 16'd0);
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_bus", data_bus, 16'h0000);
        end
        chk("idle_busy", 16'(busy), 16'd0);

        // basic three-packet burst
        launch(4'd3, 2'b00, 8'hA5);
        pkt("basic0", 16'hFA50, 4'd0);
        pkt("basic1", 16'hFA51, 4'd1);
        pkt("basic2", 16'hFA52, 4'd2);
        finish_burst("basic");

        // full-length burst with sequence wrap, payload changes every packet
        launch(4'd0, 2'b00, 8'h00);
        for (int i = 0; i < 16; i++) begin
            payload = 8'(i * 3);
            pkt("full", {4'hF, 8'(i * 3), 4'(i)}, 4'(i));
        end
        finish_burst("full");

        // next burst restarts at sequence 0
        launch(4'd2, 2'b00, 8'h5A);
        pkt("restart0", 16'hF5A0, 4'd0);
        pkt("restart1", 16'hF5A1, 4'd1);
        finish_burst("restart");

        // header error on the second packet
        launch(4'd4, 2'b01, 8'h00);
        pkt("hdr0", 16'hF000, 4'd0);
        pkt("hdr1", 16'hE001, 4'd1);
        pkt("hdr2", 16'hF002, 4'd2);
        pkt("hdr3", 16'hF003, 4'd3);
        finish_burst("hdr");

        // sequence error: skip on the second packet, later packets continue from it
        launch(4'd4, 2'b10, 8'h00);
        pkt("sq0", 16'hF000, 4'd0);
        pkt("sq1", 16'hF002, 4'd2);
        pkt("sq2", 16'hF003, 4'd3);
        pkt("sq3", 16'hF004, 4'd4);
        finish_burst("sq");

        // single packet burst never gets an error
        launch(4'd1, 2'b10, 8'h00);
        pkt("single0", 16'hF000, 4'd0);
        finish_burst("single");

        // mode 11 behaves as no error
        launch(4'd2, 2'b11, 8'h3C);
        pkt("m11_0", 16'hF3C0, 4'd0);
        pkt("m11_1", 16'hF3C1, 4'd1);
        finish_burst("m11");

        // start pulsed during the 2nd packet and during the last packet is ignored
        launch(4'd5, 2'b00, 8'h11);
        pkt("busy0", 16'hF110, 4'd0);
        pkt("busy1", 16'hF111, 4'd1);
        start     = 1'b1;
        pkt_count = 4'd2;
        pkt("busy2", 16'hF112, 4'd2);
        start = 1'b0;
        pkt("busy3", 16'hF113, 4'd3);
        pkt("busy4", 16'hF114, 4'd4);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_done", 16'(done), 16'd1);
        chk("busy_done_bus", data_bus, 16'h0000);
        tick();
        chk("busy_no_relaunch", 16'(busy), 16'd0);
        chk("busy_done_low", 16'(done), 16'd0);
        tick();
        chk("busy_still_idle", 16'(busy), 16'd0);
        chk("busy_idle_bus", data_bus, 16'h0000);

        // reset during the 3rd packet aborts the burst
        launch(4'd5, 2'b00, 8'h77);
        pkt("abort0", 16'hF770, 4'd0);
        pkt("abort1", 16'hF771, 4'd1);
        pkt("abort2", 16'hF772, 4'd2);
        #2 reset = 1'b1;
        #1;
        chk("abort_bus", data_bus, 16'h0000);
        chk("abort_busy", 16'(busy), 16'd0);
        chk("abort_seq", 16'(seq), 16'd0);
        tick();
        chk("abort_done", 16'(done), 16'd0);
        // start raised as reset releases is taken on the first edge after
        reset = 1'b0;
        launch(4'd2, 2'b00, 8'h77);
        pkt("post0", 16'hF770, 4'd0);
        pkt("post1", 16'hF771, 4'd1);
        finish_burst("post");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
